voice_allocator: RTL and testbench

Assigns each note issued by the song reader to one of the three note-player voices for polyphonic playback. Tracks per-voice busy status and relative age, and loads note/duration into the chosen voice. Steals the oldest voice when all three are busy. Sits between song_reader (new_note, note, duration) and the three note_player instances (done pulses in, load pulses out).

---
 rtl/voice_allocator_pkg.sv | 22 ++
 rtl/voice_allocator_age_tracker.sv | 52 +++++
 rtl/voice_allocator.sv | 110 +++++++++++
 tb/tb_voice_allocator.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/voice_allocator_pkg.sv
// Shared constants and types for the voice allocator and its age tracker.
// NOTE_WIDTH, DURATION_WIDTH, NUM_VOICES and REST_NOTE are the common note-path definitions.
package voice_allocator_pkg;

   localparam int unsigned NOTE_WIDTH     = 6;
   localparam int unsigned DURATION_WIDTH = 6;
   localparam int unsigned NUM_VOICES     = 3;

   localparam logic [NOTE_WIDTH-1:0] REST_NOTE = '0;

   typedef logic [1:0] rank_t;
   typedef logic [1:0] voice_idx_t;

   // Element v holds the rank of voice v: v0 oldest, v2 youngest.
   localparam rank_t [NUM_VOICES-1:0] RESET_RANKS = {rank_t'(0), rank_t'(1), rank_t'(2)};
   localparam rank_t                  OLDEST_RANK = rank_t'(NUM_VOICES - 1);

   function automatic logic [NUM_VOICES-1:0] voice_onehot(input voice_idx_t idx);
      return 3'b001 << idx;
   endfunction

endpackage

// File: rtl/voice_allocator_age_tracker.sv
// Per-voice age ranks (0 = most recently loaded, 2 = oldest); the ranks always form
// a permutation of 0..2.
module voice_age_tracker
   import voice_allocator_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     load_en,
   input  voice_idx_t               load_idx,
   output voice_idx_t               oldest_idx,
   output rank_t [NUM_VOICES-1:0]   ranks
);

   rank_t [NUM_VOICES-1:0] rank_q;
   rank_t [NUM_VOICES-1:0] rank_d;
   rank_t                  loaded_rank;

   // Loaded voice becomes youngest; only voices younger than it age by one.
   always_comb begin
      rank_d      = rank_q;
      loaded_rank = rank_q[load_idx];
      if (load_en) begin
         for (int v = 0; v < NUM_VOICES; v++) begin
            if (voice_idx_t'(v) == load_idx) begin
               rank_d[v] = '0;
            end else if (rank_q[v] < loaded_rank) begin
               rank_d[v] = rank_q[v] + rank_t'(1);
            end
         end
      end
   end

   always_comb begin
      oldest_idx = '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
         if (rank_q[v] == OLDEST_RANK) begin
            oldest_idx = voice_idx_t'(v);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rank_q <= RESET_RANKS;
      end else begin
         rank_q <= rank_d;
      end
   end

   assign ranks = rank_q;

endmodule

// File: rtl/voice_allocator.sv
// Assigns incoming notes to one of three voices: lowest free voice first, otherwise
// the oldest voice is stolen.
module voice_allocator
   import voice_allocator_pkg::*;
(
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        play,
   input  logic                        new_note,
   input  logic [NOTE_WIDTH-1:0]       note,
   input  logic [DURATION_WIDTH-1:0]   duration,
   input  logic                        note_one_done,
   input  logic                        note_two_done,
   input  logic                        note_three_done,
   output logic [NOTE_WIDTH-1:0]       note_one,
   output logic [NOTE_WIDTH-1:0]       note_two,
   output logic [NOTE_WIDTH-1:0]       note_three,
   output logic [DURATION_WIDTH-1:0]   duration_one,
   output logic [DURATION_WIDTH-1:0]   duration_two,
   output logic [DURATION_WIDTH-1:0]   duration_three,
   output logic                        new_note_one,
   output logic                        new_note_two,
   output logic                        new_note_three,
   output logic [NUM_VOICES-1:0]       voice_busy,
   output logic                        all_idle,
   output logic                        steal
);

   logic [NUM_VOICES-1:0]  done_vec;
   logic [NUM_VOICES-1:0]  busy_after_done;
   logic [NUM_VOICES-1:0]  load_vec;
   logic                   accept;
   logic                   any_free;
   voice_idx_t             free_idx;
   voice_idx_t             oldest_idx;
   voice_idx_t             target_idx;
   rank_t [NUM_VOICES-1:0] ranks;

   // Done pulses are applied before target selection so a finishing voice is reusable.
   assign done_vec        = {note_three_done, note_two_done, note_one_done};
   assign busy_after_done = voice_busy & ~done_vec;
   assign accept          = new_note && play && (note != REST_NOTE);

   always_comb begin
      any_free = 1'b0;
      free_idx = '0;
      for (int v = NUM_VOICES - 1; v >= 0; v--) begin
         if (!busy_after_done[v]) begin
            any_free = 1'b1;
            free_idx = voice_idx_t'(v);
         end
      end
   end

   assign target_idx = any_free ? free_idx : oldest_idx;
   assign load_vec   = accept ? voice_onehot(target_idx) : '0;

   voice_age_tracker u_age_tracker (
      .clk        (clk),
      .reset      (reset),
      .load_en    (accept),
      .load_idx   (target_idx),
      .oldest_idx (oldest_idx),
      .ranks      (ranks)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         note_one       <= '0;
         note_two       <= '0;
         note_three     <= '0;
         duration_one   <= '0;
         duration_two   <= '0;
         duration_three <= '0;
         new_note_one   <= 1'b0;
         new_note_two   <= 1'b0;
         new_note_three <= 1'b0;
         voice_busy     <= '0;
         steal          <= 1'b0;
      end else begin
         {new_note_three, new_note_two, new_note_one} <= load_vec;
         voice_busy <= busy_after_done | load_vec;
         steal      <= accept && !any_free;
         if (load_vec[0]) begin
            note_one     <= note;
            duration_one <= duration;
         end
         if (load_vec[1]) begin
            note_two     <= note;
            duration_two <= duration;
         end
         if (load_vec[2]) begin
            note_three     <= note;
            duration_three <= duration;
         end
      end
   end

   assign all_idle = (voice_busy == '0);

   // Ranks must remain a permutation of 0..2.
   always_ff @(posedge clk) begin
      if (!reset) begin
         assert ((ranks[0] != ranks[1]) && (ranks[0] != ranks[2]) && (ranks[1] != ranks[2])
                 && (ranks[0] <= OLDEST_RANK) && (ranks[1] <= OLDEST_RANK)
                 && (ranks[2] <= OLDEST_RANK));
      end
   end

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: directed scenarios plus a randomized run
// against a queue-based age/busy reference model.
module tb_voice_allocator;

   logic       clk = 1'b0;
   logic       reset, play, new_note;
   logic [5:0] note, duration;
   logic       note_one_done, note_two_done, note_three_done;
   logic [5:0] note_one, note_two, note_three;
   logic [5:0] duration_one, duration_two, duration_three;
   logic       new_note_one, new_note_two, new_note_three;
   logic [2:0] voice_busy;
   logic       all_idle, steal;

   int errors = 0;
   int checks = 0;

   // Reference model: order holds voices from most recently loaded to oldest.
   logic [5:0] m_note [3];
   logic [5:0] m_dur  [3];
   logic [2:0] m_busy, m_new;
   logic       m_steal;
   int         order [$];

   voice_allocator dut (
      .clk             (clk),
      .reset           (reset),
      .play            (play),
      .new_note        (new_note),
      .note            (note),
      .duration        (duration),
      .note_one_done   (note_one_done),
      .note_two_done   (note_two_done),
      .note_three_done (note_three_done),
      .note_one        (note_one),
      .note_two        (note_two),
      .note_three      (note_three),
      .duration_one    (duration_one),
      .duration_two    (duration_two),
      .duration_three  (duration_three),
      .new_note_one    (new_note_one),
      .new_note_two    (new_note_two),
      .new_note_three  (new_note_three),
      .voice_busy      (voice_busy),
      .all_idle        (all_idle),
      .steal           (steal)
   );

   always #5 clk = ~clk;

   task automatic model_step(input logic r, input logic nn, input logic [5:0] n,
                             input logic [5:0] d, input logic p, input logic [2:0] dn);
      int tgt;
      m_new   = '0;
      m_steal = 1'b0;
      if (r) begin
         m_busy = '0;
         for (int i = 0; i < 3; i++) begin
            m_note[i] = '0;
            m_dur[i]  = '0;
         end
         order = {2, 1, 0};
         return;
      end
      m_busy = m_busy & ~dn;
      if (nn && p && n != 6'd0) begin
         tgt = -1;
         for (int v = 0; v < 3; v++) if (!m_busy[v] && tgt < 0) tgt = v;
         if (tgt < 0) begin
            tgt     = order[$];
            m_steal = 1'b1;
         end
         m_note[tgt] = n;
         m_dur[tgt]  = d;
         m_busy[tgt] = 1'b1;
         m_new[tgt]  = 1'b1;
         for (int i = 0; i < order.size(); i++) begin
            if (order[i] == tgt) begin
               order.delete(i);
               break;
            end
         end
         order.push_front(tgt);
      end
   endtask

   // Apply one cycle of inputs, let the edge happen, advance the model, release pulses.
   task automatic drive(input logic r, input logic nn, input logic [5:0] n, input logic [5:0] d,
                        input logic p, input logic [2:0] dn);
      reset    = r;
      new_note = nn;
      note     = n;
      duration = d;
      play     = p;
      {note_three_done, note_two_done, note_one_done} = dn;
      @(posedge clk);
      #1;
      model_step(r, nn, n, d, p, dn);
      reset    = 1'b0;
      new_note = 1'b0;
      play     = 1'b1;
      {note_three_done, note_two_done, note_one_done} = 3'b000;
   endtask

   task automatic test_reset;
      drive(1'b1, 1'b0, 6'd0, 6'd0, 1'b1, 3'b000);
      drive(1'b1, 1'b0, 6'd0, 6'd0, 1'b1, 3'b000);
      checks++;
      if ({note_one, note_two, note_three} !== 18'd0) begin
         errors++;
         $display("FAIL reset_notes: got %h expected 0", {note_one, note_two, note_three});
      end
      checks++;
      if ({duration_one, duration_two, duration_three} !== 18'd0) begin
         errors++;
         $display("FAIL reset_durations: got %h expected 0",
                  {duration_one, duration_two, duration_three});
      end
      checks++;
      if ({new_note_three, new_note_two, new_note_one, steal} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_pulses: got %b expected 0000",
                  {new_note_three, new_note_two, new_note_one, steal});
      end
      checks++;
      if (voice_busy !== 3'b000 || all_idle !== 1'b1) begin
         errors++;
         $display("FAIL reset_busy: busy=%b idle=%b expected 000/1", voice_busy, all_idle);
      end
   endtask

   task automatic test_single;
      drive(1'b0, 1'b1, 6'd10, 6'd4, 1'b1, 3'b000);
      checks++;
      if (new_note_one !== 1'b1 || note_one !== 6'd10 || duration_one !== 6'd4) begin
         errors++;
         $display("FAIL single_load: pulse=%b note=%0d dur=%0d expected 1/10/4",
                  new_note_one, note_one, duration_one);
      end
      checks++;
      if (voice_busy !== 3'b001 || all_idle !== 1'b0) begin
         errors++;
         $display("FAIL single_busy: busy=%b idle=%b expected 001/0", voice_busy, all_idle);
      end
      drive(1'b0, 1'b0, 6'd0, 6'd0, 1'b1, 3'b000);
      checks++;
      if (new_note_one !== 1'b0 || note_one !== 6'd10 || voice_busy !== 3'b001) begin
         errors++;
         $display("FAIL single_pulse_width: pulse=%b note=%0d busy=%b expected 0/10/001",
                  new_note_one, note_one, voice_busy);
      end
   endtask

   task automatic test_fill;
      logic seen_steal = 1'b0;
      logic [5:0] notes [3] = '{6'd10, 6'd20, 6'd30};
      drive(1'b1, 1'b0, 6'd0, 6'd0, 1'b1, 3'b000);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, notes[i], 6'(i + 1), 1'b1, 3'b000);
         seen_steal |= steal;
         checks++;
         if ({new_note_three, new_note_two, new_note_one} !== (3'b001 << i)) begin
            errors++;
            $display("FAIL fill_target%0d: got %b expected %b", i,
                     {new_note_three, new_note_two, new_note_one}, 3'b001 << i);
         end
      end
      checks++;
      if (note_one !== 6'd10 || note_two !== 6'd20 || note_three !== 6'd30) begin
         errors++;
         $display("FAIL fill_notes: got %0d/%0d/%0d expected 10/20/30",
                  note_one, note_two, note_three);
      end
      checks++;
      if (voice_busy !== 3'b111 || seen_steal !== 1'b0) begin
         errors++;
         $display("FAIL fill_busy: busy=%b steal_seen=%b expected 111/0", voice_busy, seen_steal);
      end
   endtask

   task automatic test_steal;
      drive(1'b0, 1'b1, 6'd40, 6'd5, 1'b1, 3'b000);
      checks++;
      if (new_note_one !== 1'b1 || note_one !== 6'd40 || steal !== 1'b1) begin
         errors++;
         $display("FAIL steal_oldest: pulse=%b note=%0d steal=%b expected 1/40/1",
                  new_note_one, note_one, steal);
      end
      drive(1'b0, 1'b1, 6'd50, 6'd6, 1'b1, 3'b000);
      checks++;
      if (new_note_two !== 1'b1 || note_two !== 6'd50 || new_note_one !== 1'b0
          || steal !== 1'b1) begin
         errors++;
         $display("FAIL steal_next: v1=%b note=%0d v0=%b steal=%b expected 1/50/0/1",
                  new_note_two, note_two, new_note_one, steal);
      end
   endtask

   task automatic test_done_same_cycle;
      drive(1'b0, 1'b1, 6'd60, 6'd9, 1'b1, 3'b010);
      checks++;
      if (new_note_two !== 1'b1 || note_two !== 6'd60 || steal !== 1'b0
          || voice_busy !== 3'b111) begin
         errors++;
         $display("FAIL done_reuse: v1=%b note=%0d steal=%b busy=%b expected 1/60/0/111",
                  new_note_two, note_two, steal, voice_busy);
      end
   endtask

   task automatic test_rest_and_play;
      drive(1'b0, 1'b1, 6'd0, 6'd5, 1'b1, 3'b000);
      checks++;
      if ({new_note_three, new_note_two, new_note_one} !== 3'b000 || voice_busy !== 3'b111) begin
         errors++;
         $display("FAIL rest_ignored: loads=%b busy=%b expected 000/111",
                  {new_note_three, new_note_two, new_note_one}, voice_busy);
      end
      drive(1'b0, 1'b1, 6'd70, 6'd5, 1'b0, 3'b100);
      checks++;
      if ({new_note_three, new_note_two, new_note_one} !== 3'b000 || voice_busy !== 3'b011
          || note_three !== 6'd30) begin
         errors++;
         $display("FAIL play_low: loads=%b busy=%b note3=%0d expected 000/011/30",
                  {new_note_three, new_note_two, new_note_one}, voice_busy, note_three);
      end
   endtask

   task automatic test_reset_mid;
      drive(1'b0, 1'b1, 6'd33, 6'd3, 1'b1, 3'b000);
      checks++;
      if (voice_busy !== 3'b111 || new_note_three !== 1'b1) begin
         errors++;
         $display("FAIL mid_refill: busy=%b v2=%b expected 111/1", voice_busy, new_note_three);
      end
      drive(1'b1, 1'b1, 6'd5, 6'd5, 1'b1, 3'b000);
      checks++;
      if ({note_one, note_two, note_three, duration_one, duration_two, duration_three} !== 36'd0
          || {new_note_three, new_note_two, new_note_one, steal} !== 4'b0000
          || voice_busy !== 3'b000 || all_idle !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset: busy=%b idle=%b loads=%b n1=%0d expected all reset values",
                  voice_busy, all_idle, {new_note_three, new_note_two, new_note_one}, note_one);
      end
      drive(1'b0, 1'b1, 6'd12, 6'd7, 1'b1, 3'b000);
      checks++;
      if (new_note_one !== 1'b1 || note_one !== 6'd12 || voice_busy !== 3'b001) begin
         errors++;
         $display("FAIL after_reset_load: v0=%b note=%0d busy=%b expected 1/12/001",
                  new_note_one, note_one, voice_busy);
      end
   endtask

   task automatic test_random;
      logic       r, nn, p;
      logic [5:0] n, d;
      logic [2:0] dn;
      for (int c = 0; c < 600; c++) begin
         r  = ($urandom_range(0, 63) == 0);
         nn = ($urandom_range(0, 2) != 0);
         n  = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
         d  = 6'($urandom);
         p  = ($urandom_range(0, 7) != 0);
         for (int v = 0; v < 3; v++) dn[v] = ($urandom_range(0, 3) == 0);
         drive(r, nn, n, d, p, dn);
         checks++;
         if ({new_note_three, new_note_two, new_note_one} !== m_new || steal !== m_steal) begin
            errors++;
            $display("FAIL rand_load c=%0d: loads=%b steal=%b expected %b/%b", c,
                     {new_note_three, new_note_two, new_note_one}, steal, m_new, m_steal);
         end
         checks++;
         if (voice_busy !== m_busy || all_idle !== (m_busy == 3'b000)) begin
            errors++;
            $display("FAIL rand_busy c=%0d: busy=%b idle=%b expected %b", c,
                     voice_busy, all_idle, m_busy);
         end
         checks++;
         if (note_one !== m_note[0] || note_two !== m_note[1] || note_three !== m_note[2]
             || duration_one !== m_dur[0] || duration_two !== m_dur[1]
             || duration_three !== m_dur[2]) begin
            errors++;
            $display("FAIL rand_regs c=%0d: notes=%0d/%0d/%0d expected %0d/%0d/%0d", c,
                     note_one, note_two, note_three, m_note[0], m_note[1], m_note[2]);
         end
      end
   endtask

   initial begin
      reset    = 1'b1;
      play     = 1'b1;
      new_note = 1'b0;
      note     = '0;
      duration = '0;
      {note_three_done, note_two_done, note_one_done} = 3'b000;
      model_step(1'b1, 1'b0, 6'd0, 6'd0, 1'b1, 3'b000);
      test_reset();
      test_single();
      test_fill();
      test_steal();
      test_done_same_cycle();
      test_rest_and_play();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
